// File: rtl/sub_pkg.sv
// rtl/sub_pkg.sv - shared state encoding and nibble geometry for the serial subtractor
package sub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int NIB_W = 4;
    localparam int NIB_N = 8;

endpackage

// File: rtl/sub4.sv
// rtl/sub4.sv - combinational 4-bit subtractor with borrow in/out
import sub_pkg::*;

module sub4 (
    input  logic [NIB_W-1:0] a,
    input  logic [NIB_W-1:0] b,
    input  logic             bi,
    output logic [NIB_W-1:0] d,
    output logic             bo
);

    logic [NIB_W:0] diff;

    // One extra bit: it goes high exactly when a < b + bi.
    always_comb begin
        diff = {1'b0, a} - {1'b0, b} - {{NIB_W{1'b0}}, bi};
        d    = diff[NIB_W-1:0];
        bo   = diff[NIB_W];
    end

endmodule

// File: rtl/sub32_serial.sv
// rtl/sub32_serial.sv - 32-bit subtractor computing one nibble per cycle through a single sub4
import sub_pkg::*;

module sub32_serial (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        bi,
    output logic [31:0] d,
    output logic        bo,
    output logic        v,
    output logic        busy,
    output logic        done
);

    state_t state;
    state_t state_next;

    logic [31:0]             a_r;
    logic [31:0]             b_r;
    logic [31-NIB_W:0]       acc;
    logic                    brw;
    logic [2:0]              cnt;
    logic [NIB_W-1:0]        nib_d;
    logic                    nib_bo;
    logic                    last;
    logic                    accept;

    sub4 u_sub4 (
        .a  (a_r[NIB_W-1:0]),
        .b  (b_r[NIB_W-1:0]),
        .bi (brw),
        .d  (nib_d),
        .bo (nib_bo)
    );

    assign last   = (cnt == 3'(NIB_N - 1));
    assign accept = (state == IDLE) && start;
    assign busy   = (state == RUN);
    assign done   = (state == DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (last)  state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Operands shift right so the active nibble always sits at bit 0;
    // partial results collect in acc and only reach d when the last nibble is done.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_r <= '0;
            b_r <= '0;
            acc <= '0;
            brw <= 1'b0;
            cnt <= '0;
            d   <= '0;
            bo  <= 1'b0;
            v   <= 1'b0;
        end else if (accept) begin
            a_r <= a;
            b_r <= b;
            brw <= bi;
            acc <= '0;
            cnt <= '0;
            d   <= '0;
            bo  <= 1'b0;
            v   <= 1'b0;
        end else if (state == RUN) begin
            a_r <= {{NIB_W{1'b0}}, a_r[31:NIB_W]};
            b_r <= {{NIB_W{1'b0}}, b_r[31:NIB_W]};
            acc <= {nib_d, acc[31-NIB_W:NIB_W]};
            brw <= nib_bo;
            if (last) begin
                d  <= {nib_d, acc};
                bo <= nib_bo;
                v  <= (a_r[NIB_W-1] != b_r[NIB_W-1]) && (nib_d[NIB_W-1] != a_r[NIB_W-1]);
            end else begin
                cnt <= cnt + 3'd1;
            end
        end
    end

endmodule
